// File: rtl/rf_bypass_param.sv
// Multi-ported register file: two write ports, two combinational read ports
// with write-to-read bypass, optional hardwired-zero r0 and a per-register
// busy scoreboard for decode stall detection.

// One storage register plus its busy bit.
module rf_bypass_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we1,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_we2,
    input  logic [WIDTH-1:0] i_d2,
    input  logic             i_res,
    output logic [WIDTH-1:0] o_q,
    output logic             o_busy
);
    // Port 2 wins a same-register dual write; reserve wins over write-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q    <= '0;
            o_busy <= 1'b0;
        end else begin
            if (i_we2)      o_q <= i_d2;
            else if (i_we1) o_q <= i_d1;
            if (i_res)                o_busy <= 1'b1;
            else if (i_we1 || i_we2)  o_busy <= 1'b0;
        end
    end
endmodule

// One combinational read port with bypass and busy masking.
module rf_read_port #(
    parameter int WIDTH   = 16,
    parameter int SEL_W   = 3,
    parameter int ZERO_R0 = 0,
    parameter int NREGS   = 2**SEL_W
) (
    input  logic [SEL_W-1:0]            i_sel,
    input  logic                        i_rst,
    input  logic [NREGS-1:0][WIDTH-1:0] i_q,
    input  logic [NREGS-1:0]            i_busy,
    input  logic                        i_we1,
    input  logic [SEL_W-1:0]            i_wsel1,
    input  logic [WIDTH-1:0]            i_wd1,
    input  logic                        i_we2,
    input  logic [SEL_W-1:0]            i_wsel2,
    input  logic [WIDTH-1:0]            i_wd2,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_busy
);
    // Priority: hardwired r0, reset (storage only), port 2, port 1, storage.
    always_comb begin
        o_data = i_q[i_sel];
        o_busy = i_busy[i_sel];
        if (ZERO_R0 != 0 && i_sel == '0) begin
            o_data = '0;
            o_busy = 1'b0;
        end else if (!i_rst) begin
            if (i_we2 && i_wsel2 == i_sel) begin
                o_data = i_wd2;
                o_busy = 1'b0;
            end else if (i_we1 && i_wsel1 == i_sel) begin
                o_data = i_wd1;
                o_busy = 1'b0;
            end
        end
    end
endmodule

module rf_bypass_param #(
    parameter int WIDTH   = 16,
    parameter int SEL_W   = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] read1RegSel,
    input  logic [SEL_W-1:0] read2RegSel,
    output logic [WIDTH-1:0] read1OutData,
    output logic [WIDTH-1:0] read2OutData,
    output logic             read1Busy,
    output logic             read2Busy,
    input  logic [SEL_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0] writeInData,
    input  logic             writeEn,
    input  logic [SEL_W-1:0] write2RegSel,
    input  logic [WIDTH-1:0] write2InData,
    input  logic             write2En,
    input  logic [SEL_W-1:0] reserveSel,
    input  logic             reserveEn,
    output logic             err
);
    localparam int NREGS = 2**SEL_W;

    logic [NREGS-1:0][WIDTH-1:0] w_q;
    logic [NREGS-1:0]            w_busy;
    logic [SEL_W-1:0]            w_rsel  [2];
    logic [WIDTH-1:0]            w_rdata [2];
    logic                        w_rbusy [2];
    logic                        w_xin;
    logic                        w_dual;

    // Storage array; r0 enables are tied off when it is hardwired to zero.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam bit LIVE = !(ZERO_R0 != 0 && r == 0);
        logic w_we1, w_we2, w_res;
        assign w_we1 = LIVE && writeEn   && (writeRegSel  == SEL_W'(r));
        assign w_we2 = LIVE && write2En  && (write2RegSel == SEL_W'(r));
        assign w_res = LIVE && reserveEn && (reserveSel   == SEL_W'(r));
        rf_bypass_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_we1  (w_we1),
            .i_d1   (writeInData),
            .i_we2  (w_we2),
            .i_d2   (write2InData),
            .i_res  (w_res),
            .o_q    (w_q[r]),
            .o_busy (w_busy[r])
        );
    end

    assign w_rsel[0] = read1RegSel;
    assign w_rsel[1] = read2RegSel;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rf_read_port #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ZERO_R0(ZERO_R0)) u_port (
            .i_sel   (w_rsel[p]),
            .i_rst   (rst),
            .i_q     (w_q),
            .i_busy  (w_busy),
            .i_we1   (writeEn),
            .i_wsel1 (writeRegSel),
            .i_wd1   (writeInData),
            .i_we2   (write2En),
            .i_wsel2 (write2RegSel),
            .i_wd2   (write2InData),
            .o_data  (w_rdata[p]),
            .o_busy  (w_rbusy[p])
        );
    end

    assign read1OutData = w_rdata[0];
    assign read2OutData = w_rdata[1];
    assign read1Busy    = w_rbusy[0];
    assign read2Busy    = w_rbusy[1];

    // Unknown inputs are a simulation-only error source; hardware sees 0.
    assign w_xin = $isunknown({clk, rst, read1RegSel, read2RegSel,
                               writeRegSel, writeInData, writeEn,
                               write2RegSel, write2InData, write2En,
                               reserveSel, reserveEn});

    // Dual write to one register, except a discarded hardwired r0.
    assign w_dual = writeEn && write2En && (writeRegSel == write2RegSel) &&
                    !(ZERO_R0 != 0 && writeRegSel == '0);

    assign err = w_xin || w_dual;
endmodule

// File: doc/rf_bypass_param.md
# rf_bypass_param

Parametrised multi-ported register file with two write ports, two combinational read ports, write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard. It is the next-generation register file for the processor datapath: decode reads operands and reserves destinations, while writeback and a second completion port retire results. Width, register count and the r0 mode are parameters. Bypass and the scoreboard remove the one-cycle write-to-read bubble and let decode stall on pending registers.

## Interface
- WIDTH, 16, data width in bits (>=1)
- SEL_W, 3, register select width; register count NREGS = 2**SEL_W
- ZERO_R0, 0, when 1: register 0 reads as all-zero, is never written, and is never busy

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- read1RegSel, read2RegSel  in  SEL_W  read port selects
- read1OutData, read2OutData  out  WIDTH  read data, combinational
- read1Busy, read2Busy  out  1  scoreboard status of the selected register, combinational
- writeRegSel  in  SEL_W  write port 1 select
- writeInData  in  WIDTH  write port 1 data
- writeEn  in  1  write port 1 enable
- write2RegSel  in  SEL_W  write port 2 select
- write2InData  in  WIDTH  write port 2 data
- write2En  in  1  write port 2 enable
- reserveSel  in  SEL_W  register to mark busy
- reserveEn  in  1  reserve enable
- err  out  1  error flag, combinational

## Operation
- State: NREGS x WIDTH data registers and NREGS busy bits.
- Write: at the edge, reg[writeRegSel] <= writeInData if writeEn. Port 2 behaves the same way.
- Write conflict: if both ports are enabled to the same register, port 2 data is stored and err=1 for that cycle.
- Read data priority for port k (each read port evaluated independently):
  1. ZERO_R0=1 and sel==0 -> 0.
  2. rst=1 -> stored value (no bypass).
  3. write2En and write2RegSel==sel -> write2InData.
  4. writeEn and writeRegSel==sel -> writeInData.
  5. Otherwise -> stored reg[sel].
- Scoreboard update at the edge, for each register r:
  - reserveEn and reserveSel==r -> busy[r]=1. Reserve wins over a same-cycle write; the data write still happens.
  - Otherwise, a write by either port to r -> busy[r]=0.
  - Otherwise, busy[r] holds.
- Busy output: readkBusy = busy[sel], forced to 0 when a same-cycle write (either port) targets sel and rst=0. It is always 0 for r0 when ZERO_R0=1.
- ZERO_R0=1: writes and reserves to r0 are discarded and raise no conflict err.
- err is asserted when:
  - any input (clk, rst, selects, data, enables) contains X/Z, or
  - a dual write to the same register occurs (excluding r0 when ZERO_R0=1).
  - err is otherwise 0.

## Timing
- Reads, bypass, busy and err are zero-latency combinational outputs.
- A write is visible the same cycle via bypass and from storage on the next cycle.
- A reserve is visible on readkBusy the cycle after reserveEn.
- Reset: rst=1 at an edge clears all data registers to 0 and all busy bits to 0.
  - Writes and reserves are ignored while rst=1.
  - While rst=1, reads return stored values, busy outputs report stored bits unmodified, and err follows the input rules above.
- Reset mid-operation: a write or reserve coinciding with rst is lost. From the first cycle after the reset edge, all reads return 0 and all busy outputs are 0.
- Select wrap-around is impossible: every SEL_W value addresses a valid register.

## Test plan
- Reset then read: rst=1 for 1 edge with writeEn=1, sel 3, data 0xBEEF -> next cycle read1/read2 of every register = 0x0000, busy=0, err=0.
- Write then read, with bypass: write 0x1234 to r5 via port 1 with read1RegSel=5 in the same cycle -> read1OutData=0x1234 that cycle, and 0x1234 from storage after the edge with writeEn=0.
- Dual-write conflict: port 1 writes 0xAAAA and port 2 writes 0x5555, both to r2 -> err=1 that cycle; r2 reads 0x5555 afterward.
- Scoreboard:
  - reserveEn, sel 4 -> read1Busy=1 next cycle.
  - Then write 0x0F0F to r4 via port 2 -> read1Busy=0 the same cycle; busy bit clear after the edge.
  - Reserve and write r4 together -> busy=1 and data stored.
- ZERO_R0=1 instance: write 0xFFFF to r0 and reserve r0 -> read r0 = 0, busy=0, err=0, no bypass.
- Parameter sweep: WIDTH=32, SEL_W=4, write 0xDEADBEEF to r15 -> reads back correctly; r14 stays 0. Drive writeInData with X -> err=1.
